event_blinker: RTL and testbench
================================

// Module: event_blinker
// PURPOSE
//  Output-side counterpart of the button debouncer: converts single-cycle event pulses
//  (e.g. a debounced Enable strobe) into human-visible LED blinks.
//  Each accepted event produces exactly one ON_CYCLES-long high pulse on Led, followed by
//  an OFF_CYCLES-long low gap. Events arriving while a blink is active are queued in a
//  saturating pending counter, so N presses produce N distinct blinks.
// PARAMETERS
//  ON_CYCLES   25000000  Led high time per blink in CLK cycles (>=1; 250 ms @ 100 MHz)
//  OFF_CYCLES  25000000  mandatory Led low gap after every blink in CLK cycles (>=1)
//  CNT_W       25        phase counter width; must hold max(ON_CYCLES,OFF_CYCLES)-1
//  DEPTH_W     4         pending counter width; max queued events = 2**DEPTH_W-1
// PORTS
//  CLK       in   1        system clock, all state on posedge
//  RST_N     in   1        asynchronous active-low reset
//  Event     in   1        event strobe; every cycle sampled high counts as one event
//  Led       out  1        registered blink output
//  Busy      out  1        1 whenever state != IDLE
//  Pending   out  DEPTH_W  queued events not yet started
//  Overflow  out  1        sticky: an event was dropped due to a full queue; cleared by reset only
// BEHAVIOUR
//  Reset (RST_N=0, async, effective immediately, also mid-blink): state=IDLE, counter=0,
//   Led=0, Busy=0, Pending=0, Overflow=0.
//  States: IDLE, ON, OFF. All outputs registered; no combinational path Event->Led.
//  IDLE: edge with Event=1 -> ON, counter=0, Led=1; Pending unchanged (latency 1 cycle).
//  ON: counter increments each edge; at edge with counter==ON_CYCLES-1 -> OFF, counter=0,
//   Led=0. Led is therefore high for exactly ON_CYCLES cycles.
//  OFF: counter increments; at edge with counter==OFF_CYCLES-1:
//   - Pending>0 or Event=1 -> ON, counter=0, Led=1 (no IDLE cycle inserted).
//   - otherwise -> IDLE. Led is low for exactly OFF_CYCLES cycles between blinks.
//  OFF is always entered after ON, even when Pending==0 (guaranteed visible gap).
//  Pending update per edge, in ON/OFF only (inc = Event, dec = OFF->ON transition):
//   - inc only: Pending+1 if Pending<max; at max, Pending holds and Overflow<=1.
//   - dec only: Pending-1.
//   - inc and dec together: Pending unchanged, no Overflow (the new event is the one started).
//   - dec taken with Pending==0 only when Event=1 -> consumes that event directly; Pending stays 0.
//  Event held high for K cycles = K events (upstream must supply single-cycle strobes).
//  Counter never wraps: it is reset on every state change; comparisons are at width CNT_W.
//  Busy is derived from the registered state: 1 in ON and OFF, 0 in IDLE.
// TESTING  (sim params: ON_CYCLES=4, OFF_CYCLES=3, DEPTH_W=2)
//  1 Event=1 at edge 0 in IDLE -> Led=1 cycles 1-4, Led=0 cycles 5-7, Busy=0 from cycle 8, Pending=0.
//  2 Event at edge 0, then 2 more strobes during ON -> Pending=2, then 1, then 0; 3 blinks each
//    4 high / 3 low; Busy drops 3 cycles after the final Led fall.
//  3 Event at edge 0, then 5 strobes during ON -> Pending saturates at 3, Overflow=1 and stays
//    1 after the queue drains; total 4 blinks.
//  4 Pending=0, Event on the last OFF cycle -> Led rises on the next cycle, Busy never drops,
//    Pending remains 0.
//  5 Pending=3 (full), Event on the same edge as the OFF->ON transition -> Pending stays 3,
//    Overflow stays 0.
//  6 RST_N pulled low mid-ON with Pending=2 -> Led, Busy, Pending, Overflow all 0 immediately
//    (before the next CLK edge); after release, a single Event produces one normal blink.

Source files
------------

// File: rtl/event_blinker_if.sv
// event_blinker_if: event-in / blink-out bundle for event_blinker.
//  Event    event strobe toward the blinker (one event per sampled-high cycle)
//  Led      registered blink output
//  Busy     blinker is in ON or OFF phase
//  Pending  queued events not yet started
//  Overflow sticky queue-full drop flag
// slave  = blinker side, master = event source / LED observer side.
interface event_blinker_if #(
  parameter int DEPTH_W = 4
);
  logic               Event;
  logic               Led;
  logic               Busy;
  logic [DEPTH_W-1:0] Pending;
  logic               Overflow;

  modport slave  (input  Event, output Led, Busy, Pending, Overflow);
  modport master (output Event, input  Led, Busy, Pending, Overflow);
endinterface

// File: rtl/event_blinker.sv
// event_blinker: turns single-cycle event strobes into visible LED blinks.
// Each accepted event gives ON_CYCLES of Led high then OFF_CYCLES of Led low.
// Events arriving mid-blink queue in a saturating pending counter; a dropped
// event sets the sticky Overflow flag.
//  CLK    in  system clock (posedge)
//  RST_N  in  asynchronous active-low reset
//  bus    slave modport: Event in; Led, Busy, Pending, Overflow out
module event_blinker #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 25000000,
  parameter int CNT_W      = 25,
  parameter int DEPTH_W    = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  event_blinker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [CNT_W-1:0]   ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [DEPTH_W-1:0] PEND_MAX = '1;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
  logic               r_led,   w_led_nx;
  logic [DEPTH_W-1:0] r_pend,  w_pend_nx;
  logic               r_ovf,   w_ovf_nx;
  logic               w_dec;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_led   <= 1'b0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_led   <= w_led_nx;
      r_pend  <= w_pend_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    w_led_nx   = r_led;
    w_pend_nx  = r_pend;
    w_ovf_nx   = r_ovf;
    w_dec      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (bus.Event) begin
          w_state_nx = S_ON;
          w_led_nx   = 1'b1;
        end
      end
      S_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nx = S_OFF;
          w_cnt_nx   = '0;
          w_led_nx   = 1'b0;
        end
      end
      S_OFF: begin
        if (r_cnt == OFF_LAST) begin
          w_cnt_nx = '0;
          // A strobe on this very edge may start the next blink directly,
          // so no IDLE cycle is inserted between back-to-back blinks.
          if (r_pend != '0 || bus.Event) begin
            w_state_nx = S_ON;
            w_led_nx   = 1'b1;
            w_dec      = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_led_nx   = 1'b0;
      end
    endcase

    // Queue only counts while a blink is in progress; in IDLE the event is
    // consumed by the IDLE->ON start. Simultaneous inc+dec cancel out, which
    // also covers the "start the event that just arrived" case at Pending==0.
    if (r_state != S_IDLE) begin
      if (bus.Event && !w_dec) begin
        if (r_pend == PEND_MAX) w_ovf_nx  = 1'b1;
        else                    w_pend_nx = r_pend + DEPTH_W'(1);
      end else if (!bus.Event && w_dec) begin
        w_pend_nx = r_pend - DEPTH_W'(1);
      end
    end
  end

  assign bus.Led      = r_led;
  assign bus.Busy     = (r_state != S_IDLE);
  assign bus.Pending  = r_pend;
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_event_blinker.sv
module tb_event_blinker;
  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int DW  = 2;

  logic CLK = 1'b0;
  logic RST_N;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  event_blinker_if #(.DEPTH_W(DW)) bus ();

  event_blinker #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(3), .DEPTH_W(DW)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // One record per expected blink: edge of the Led rise, Pending and Overflow seen then.
  typedef struct {
    int rise;
    int pend;
    int ovf;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int rise, input int pend, input int ovf);
    exp_t e;
    e.rise = rise; e.pend = pend; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Drive Event for the next posedge; return just after the following negedge,
  // at which point cyc equals the edge that sampled the value.
  task automatic step(input logic ev);
    bus.Event = ev;
    @(negedge CLK);
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) step(1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_led"},  int'(bus.Led),      0);
    chk({tag, "_busy"}, int'(bus.Busy),     0);
    chk({tag, "_pend"}, int'(bus.Pending),  0);
    chk({tag, "_ovf"},  int'(bus.Overflow), 0);
  endtask

  task automatic do_reset(input string tag);
    bus.Event = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_zero(tag);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Monitor: every Led rise pops a blink record; every Led fall checks the high time.
  logic prev_led = 1'b0;
  int   hi_len   = 0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_led = 1'b0;
      hi_len   = 0;
    end else begin
      if (bus.Led && !prev_led) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_blink", cyc, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rise_cyc",  cyc,               e.rise);
          chk("rise_pend", int'(bus.Pending),  e.pend);
          chk("rise_ovf",  int'(bus.Overflow), e.ovf);
        end
        hi_len = 0;
      end
      if (bus.Led) hi_len++;
      if (!bus.Led && prev_led) chk("high_len", hi_len, ON);
      prev_led = bus.Led;
    end
  end

  initial begin
    int e0;
    RST_N     = 1'b0;
    bus.Event = 1'b0;
    repeat (2) @(negedge CLK);
    chk_zero("por");
    #2 RST_N = 1'b1;
    @(negedge CLK);

    // 1: single event -> one 4-high / 3-low blink, Busy clears at e0+7
    e0 = cyc + 1;
    push(e0, 0, 0);
    step(1'b1);
    chk("t1_led_on", int'(bus.Led), 1);
    idle_to(e0 + 6);
    chk("t1_busy_last_off", int'(bus.Busy), 1);
    step(1'b0);
    chk_zero("t1_end");

    // 2: two queued strobes -> three blinks, Pending 2 -> 1 -> 0
    e0 = cyc + 1;
    push(e0, 0, 0); push(e0 + 7, 1, 0); push(e0 + 14, 0, 0);
    step(1'b1);
    step(1'b1);
    chk("t2_pend1", int'(bus.Pending), 1);
    step(1'b1);
    chk("t2_pend2", int'(bus.Pending), 2);
    idle_to(e0 + 20);
    chk("t2_busy_hold", int'(bus.Busy), 1);
    step(1'b0);
    chk("t2_busy_drop", int'(bus.Busy), 0);

    // 3: five strobes after start -> Pending saturates at 3, Overflow sticks
    e0 = cyc + 1;
    push(e0, 0, 0); push(e0 + 7, 2, 1); push(e0 + 14, 1, 1); push(e0 + 21, 0, 1);
    step(1'b1);
    step(1'b1); step(1'b1); step(1'b1);
    chk("t3_pend_full", int'(bus.Pending),  3);
    chk("t3_ovf_before", int'(bus.Overflow), 0);
    step(1'b1); step(1'b1);
    chk("t3_pend_sat", int'(bus.Pending),  3);
    chk("t3_ovf_set",  int'(bus.Overflow), 1);
    idle_to(e0 + 28);
    chk("t3_busy_drop", int'(bus.Busy),     0);
    chk("t3_pend_zero", int'(bus.Pending),  0);
    chk("t3_ovf_stick", int'(bus.Overflow), 1);
    do_reset("t3_rst");

    // 4: event on the last OFF edge with Pending==0 -> back-to-back blink
    e0 = cyc + 1;
    push(e0, 0, 0); push(e0 + 7, 0, 0);
    step(1'b1);
    while (cyc < e0 + 6) begin
      step(1'b0);
      chk("t4_busy", int'(bus.Busy), 1);
    end
    step(1'b1);
    chk("t4_busy_turn", int'(bus.Busy),    1);
    chk("t4_pend_turn", int'(bus.Pending), 0);
    idle_to(e0 + 13);
    chk("t4_busy_end", int'(bus.Busy), 1);
    step(1'b0);
    chk("t4_busy_drop", int'(bus.Busy), 0);

    // 5: full queue plus event on the OFF->ON edge -> Pending stays 3, no Overflow
    e0 = cyc + 1;
    push(e0, 0, 0); push(e0 + 7, 3, 0); push(e0 + 14, 2, 0);
    push(e0 + 21, 1, 0); push(e0 + 28, 0, 0);
    step(1'b1);
    step(1'b1); step(1'b1); step(1'b1);
    chk("t5_pend_full", int'(bus.Pending), 3);
    idle_to(e0 + 6);
    step(1'b1);
    chk("t5_pend_hold", int'(bus.Pending),  3);
    chk("t5_ovf_clear", int'(bus.Overflow), 0);
    idle_to(e0 + 35);
    chk("t5_busy_drop", int'(bus.Busy),     0);
    chk("t5_ovf_end",   int'(bus.Overflow), 0);

    // 6: reset mid-ON with Pending==2 clears everything before the next edge
    e0 = cyc + 1;
    push(e0, 0, 0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("t6_pend2", int'(bus.Pending), 2);
    chk("t6_led",   int'(bus.Led),     1);
    do_reset("t6_rst");
    e0 = cyc + 1;
    push(e0, 0, 0);
    step(1'b1);
    idle_to(e0 + 6);
    chk("t6_busy_after", int'(bus.Busy), 1);
    step(1'b0);
    chk_zero("t6_end");

    repeat (3) step(1'b0);
    chk("sb_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000 ns");
    $fatal(1);
  end
endmodule
